s_axi_ddr_model: RTL

S_AXI_DDR_MODEL -- requirements
Module: s_axi_ddr_model

---
 rtl/s_axi_ddr_model_pkg.sv | 20 ++
 rtl/axi_rd_skid.sv | 61 ++++++
 rtl/s_axi_ddr_model.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_axi_ddr_model_pkg.sv
// Shared definitions for the AXI DDR behavioural slave: response codes and
// the state encodings of the independent write and read FSMs.
package s_axi_ddr_model_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi_rd_skid.sv
// Two-entry valid/ready buffer on the R channel. The head entry drives the
// outputs and only changes when it is consumed, so data stays stable under
// back-pressure. The producer must respect 'level' (it never pushes into a
// full buffer unless a pop happens in the same cycle).
module axi_rd_skid #(
  parameter int W = 8
) (
  input  logic         I_clk,
  input  logic         I_rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);

  logic [W-1:0] head;
  logic [W-1:0] spare;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign push      = in_valid;
  assign pop       = (count != 2'd0) && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign level     = count;

  // Push/pop bookkeeping; the head only moves when it is popped or empty.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      count <= 2'd0;
      head  <= '0;
      spare <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               spare <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= spare;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head  <= spare;
            spare <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/s_axi_ddr_model.sv
// Behavioural AXI4 slave backed by a simple-dual-port RAM. Write and read
// directions each run one INCR burst at a time, concurrently. Reads are
// prefetched from the RAM into a two-entry skid buffer so the R channel
// sustains one beat per cycle and holds steady under back-pressure.
module s_axi_ddr_model
  import s_axi_ddr_model_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_MEM_WORDS  = 4096,
  parameter int C_RD_LAT     = 4
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic                      I_awvalid,
  output logic                      O_awready,
  input  logic [C_ADDR_WIDTH-1:0]   I_awaddr,
  input  logic [7:0]                I_awlen,
  input  logic [3:0]                I_awid,
  input  logic                      I_wvalid,
  output logic                      O_wready,
  input  logic [C_DATA_WIDTH-1:0]   I_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] I_wstrb,
  input  logic                      I_wlast,
  output logic                      O_bvalid,
  input  logic                      I_bready,
  output logic [1:0]                O_bresp,
  output logic [3:0]                O_bid,
  input  logic                      I_arvalid,
  output logic                      O_arready,
  input  logic [C_ADDR_WIDTH-1:0]   I_araddr,
  input  logic [7:0]                I_arlen,
  input  logic [3:0]                I_arid,
  output logic                      O_rvalid,
  input  logic                      I_rready,
  output logic [C_DATA_WIDTH-1:0]   O_rdata,
  output logic [1:0]                O_rresp,
  output logic [3:0]                O_rid,
  output logic                      O_rlast
);

  localparam int STRB_W   = C_DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(C_MEM_WORDS);
  localparam int SKID_W   = C_DATA_WIDTH + 5;
  localparam int WAIT_W   = ($clog2(C_RD_LAT + 1) < 1) ? 1 : $clog2(C_RD_LAT + 1);
  // The last RD_WAIT cycle already issues the first RAM read, so the wait
  // is two shorter than the AR-to-R latency (RAM register + skid register).
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (C_RD_LAT >= 2) ? WAIT_W'(C_RD_LAT - 2) : '0;

  logic [C_DATA_WIDTH-1:0] mem [C_MEM_WORDS];

  // Only the beat-index bits of the byte addresses select RAM words.
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic             addr_bits_unused;

  assign aw_idx = I_awaddr[BYTE_LSB +: IDX_W];
  assign ar_idx = I_araddr[BYTE_LSB +: IDX_W];
  assign addr_bits_unused = ^{I_awaddr[BYTE_LSB-1:0], I_awaddr[C_ADDR_WIDTH-1:BYTE_LSB+IDX_W],
                              I_araddr[BYTE_LSB-1:0], I_araddr[C_ADDR_WIDTH-1:BYTE_LSB+IDX_W]};

  // ---------------------------------------------------------------- write
  wr_state_t        wr_state;
  wr_state_t        wr_state_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_beat;
  logic [7:0]       wr_len;
  logic [3:0]       wr_id;
  logic             wr_err;
  logic             wr_over;
  logic             aw_hs;
  logic             w_hs;
  logic             wr_en;

  assign aw_hs = I_awvalid && O_awready;
  assign w_hs  = I_wvalid && O_wready;
  // Beats past awlen are still accepted but never reach the RAM.
  assign wr_en = w_hs && !wr_over;

  // Write FSM state register.
  always_ff @(posedge I_clk) begin
    if (I_rst) wr_state <= WR_IDLE;
    else       wr_state <= wr_state_nxt;
  end

  // Write FSM next state; channel ready/valid flags depend on state only.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_state_nxt = wr_state;
    O_awready    = 1'b0;
    O_wready     = 1'b0;
    O_bvalid     = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        O_awready = 1'b1;
        if (I_awvalid) wr_state_nxt = WR_DATA;
      end
      WR_DATA: begin
        O_wready = 1'b1;
        if (I_wvalid && I_wlast) wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        O_bvalid = 1'b1;
        if (I_bready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write burst bookkeeping: latch AW, walk the beat index, flag wlast errors.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_idx  <= '0;
      wr_beat <= 8'd0;
      wr_len  <= 8'd0;
      wr_id   <= 4'd0;
      wr_err  <= 1'b0;
      wr_over <= 1'b0;
    end else if (aw_hs) begin
      wr_idx  <= aw_idx;
      wr_len  <= I_awlen;
      wr_id   <= I_awid;
      wr_beat <= 8'd0;
      wr_err  <= 1'b0;
      wr_over <= 1'b0;
    end else if (w_hs) begin
      if (!wr_over) begin
        wr_idx  <= wr_idx + IDX_W'(1);
        wr_beat <= wr_beat + 8'd1;
      end
      if (I_wlast) begin
        if (wr_over || (wr_beat != wr_len)) wr_err <= 1'b1;
      end else if (!wr_over && (wr_beat == wr_len)) begin
        wr_err  <= 1'b1;
        wr_over <= 1'b1;
      end
    end
  end

  assign O_bresp = wr_err ? RESP_SLVERR : RESP_OKAY;
  assign O_bid   = wr_id;

  // ----------------------------------------------------------------- read
  rd_state_t               rd_state;
  rd_state_t               rd_state_nxt;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        rd_issue_idx;
  logic [8:0]              rd_left;
  logic [3:0]              rd_id;
  logic [WAIT_W-1:0]       rd_wait;
  logic                    ar_hs;
  logic                    r_hs;
  logic                    fast_issue;
  logic                    rd_issue;
  logic                    rd_issue_last;
  logic                    room;
  logic [2:0]              occ;
  logic                    ram_rvalid;
  logic                    ram_rlast;
  logic [C_DATA_WIDTH-1:0] ram_rdata;
  logic [1:0]              skid_level;
  logic [SKID_W-1:0]       skid_out;
  logic                    skid_valid;

  assign ar_hs      = I_arvalid && O_arready;
  assign r_hs       = skid_valid && I_rready;
  // With a one-cycle latency the first beat is fetched on the AR handshake itself.
  assign fast_issue = (C_RD_LAT == 1) && ar_hs;
  // Skid entries plus the beat in flight in the RAM register must never exceed two.
  assign occ  = {1'b0, skid_level} + {2'b00, ram_rvalid};
  assign room = (occ < 3'd2) || ((occ == 3'd2) && r_hs);

  // Read FSM state register.
  always_ff @(posedge I_clk) begin
    if (I_rst) rd_state <= RD_IDLE;
    else       rd_state <= rd_state_nxt;
  end

  // Read FSM next state; arready depends on state only.
  always_comb begin
    rd_state_nxt = rd_state;
    O_arready    = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        O_arready = 1'b1;
        if (I_arvalid) rd_state_nxt = RD_WAIT;
      end
      RD_WAIT: if (rd_wait == '0) rd_state_nxt = RD_DATA;
      RD_DATA: if (r_hs && O_rlast) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // RAM read issue: prefetch while beats remain and the skid buffer has room.
  always_comb begin
    rd_issue      = 1'b0;
    rd_issue_idx  = rd_idx;
    rd_issue_last = (rd_left == 9'd1);
    if (rd_state == RD_IDLE) begin
      if (fast_issue) begin
        rd_issue      = 1'b1;
        rd_issue_idx  = ar_idx;
        rd_issue_last = (I_arlen == 8'd0);
      end
    end else if (((rd_state == RD_DATA) || ((rd_state == RD_WAIT) && (rd_wait == '0)))
                 && (rd_left != 9'd0) && room) begin
      rd_issue = 1'b1;
    end
  end

  // Read burst bookkeeping: latch AR, run the latency wait, count issued beats.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rd_idx     <= '0;
      rd_left    <= 9'd0;
      rd_id      <= 4'd0;
      rd_wait    <= '0;
      ram_rvalid <= 1'b0;
      ram_rlast  <= 1'b0;
    end else begin
      ram_rvalid <= rd_issue;
      ram_rlast  <= rd_issue_last;
      if (ar_hs) begin
        rd_id   <= I_arid;
        rd_wait <= WAIT_LOAD;
        if (fast_issue) begin
          rd_idx  <= ar_idx + IDX_W'(1);
          rd_left <= {1'b0, I_arlen};
        end else begin
          rd_idx  <= ar_idx;
          rd_left <= {1'b0, I_arlen} + 9'd1;
        end
      end else begin
        if ((rd_state == RD_WAIT) && (rd_wait != '0)) rd_wait <= rd_wait - WAIT_W'(1);
        if (rd_issue) begin
          rd_idx  <= rd_idx + IDX_W'(1);
          rd_left <= rd_left - 9'd1;
        end
      end
    end
  end

  // Simple-dual-port RAM with byte strobes; the read port returns old data on a same-index write.
  // NOTE: the RAM array has no reset, so its contents survive I_rst and it maps onto block RAM.
  always_ff @(posedge I_clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (I_wstrb[b]) mem[wr_idx][8*b +: 8] <= I_wdata[8*b +: 8];
      end
    end
    if (rd_issue) ram_rdata <= mem[rd_issue_idx];
  end

  axi_rd_skid #(
    .W (SKID_W)
  ) u_skid (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .in_valid  (ram_rvalid),
    .in_data   ({ram_rlast, rd_id, ram_rdata}),
    .out_valid (skid_valid),
    .out_ready (I_rready),
    .out_data  (skid_out),
    .level     (skid_level)
  );

  assign O_rvalid = skid_valid;
  assign O_rdata  = skid_out[C_DATA_WIDTH-1:0];
  assign O_rid    = skid_out[C_DATA_WIDTH +: 4];
  assign O_rlast  = skid_valid && skid_out[C_DATA_WIDTH+4];
  assign O_rresp  = RESP_OKAY;

endmodule
